// File: rtl/ssd_scan_ctrl_if.sv
// ssd_scan_ctrl_if
// Bundles the load/value request and the display outputs of ssd_scan_ctrl.
//   load       : single-cycle request to convert and display value
//   value      : binary value to display
//   busy       : conversion in progress
//   ovf        : last accepted value did not fit in DIGITS decimal digits
//   digit_code : BCD nibble for the enabled digit (4'hF = blank)
//   digit_sel  : active-low one-hot digit enable
// master drives the request side; slave is the controller.
interface ssd_scan_ctrl_if #(
  parameter int DIGITS = 4,
  parameter int WIDTH  = 14
);
  logic              load;
  logic [WIDTH-1:0]  value;
  logic              busy;
  logic              ovf;
  logic [3:0]        digit_code;
  logic [DIGITS-1:0] digit_sel;

  modport master (output load, value, input busy, ovf, digit_code, digit_sel);
  modport slave  (input load, value, output busy, ovf, digit_code, digit_sel);
endinterface

// File: rtl/ssd_scan_ctrl.sv
// ssd_scan_ctrl
// Converts a binary value to BCD with a sequential double-dabble engine and
// time-multiplexes the digits onto one shared seven-segment decoder.
//   clk   : system clock, rising edge
//   rst_n : asynchronous active-low reset
//   bus   : ssd_scan_ctrl_if.slave (load/value in; busy/ovf/digit_code/digit_sel out)
//
// state | meaning
// IDLE  | waiting for load; display shows shadow register
// CONV  | shifting one bit per clock, WIDTH iterations
module ssd_scan_ctrl #(
  parameter int DIGITS = 4,
  parameter int WIDTH  = 14,
  parameter int DIV    = 50000,
  parameter int LZB    = 1
) (
  input  logic           clk,
  input  logic           rst_n,
  ssd_scan_ctrl_if.slave bus
);

  // Decimal digits needed for 2^WIDTH-1, i.e. ceil(WIDTH*log10(2)).
  function automatic int calc_nibbles(input int w);
    longint unsigned m;
    int n;
    m = (64'd1 << w) - 64'd1;
    n = 0;
    for (int i = 0; i < 20; i++) begin
      if (m != 0) begin
        m = m / 10;
        n++;
      end
    end
    return n;
  endfunction

  function automatic longint unsigned pow10(input int d);
    longint unsigned p;
    p = 1;
    for (int i = 0; i < d; i++) p = p * 10;
    return p;
  endfunction

  localparam int NB_RAW = calc_nibbles(WIDTH);
  // Keep at least DIGITS nibbles so the shadow copy never reads past the accumulator.
  localparam int NB     = (NB_RAW > DIGITS) ? NB_RAW : DIGITS;
  localparam int CW     = $clog2(WIDTH + 1);
  localparam int PW     = $clog2(DIV);
  localparam int IW     = (DIGITS > 1) ? $clog2(DIGITS) : 1;
  localparam logic [63:0] OVF_LIMIT = 64'(pow10(DIGITS));

  typedef enum logic {IDLE, CONV} state_t;

  state_t              state, state_nxt;
  logic                start, done;
  logic [WIDTH-1:0]    bin;
  logic [NB*4-1:0]     bcd, bcd_adj;
  logic [NB*4+WIDTH-1:0] cat_shift;
  logic [CW-1:0]       cnt;
  logic                ovf_next, ovf_q;
  logic [DIGITS*4-1:0] shadow;
  logic [PW-1:0]       presc;
  logic                tick;
  logic [IW-1:0]       idx, idx_nxt;
  logic [DIGITS-1:0]   sel_q;
  logic [3:0]          shown [DIGITS];
  logic                lead;
  logic [3:0]          nib;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    start     = 1'b0;
    done      = 1'b0;
    case (state)
      IDLE: if (bus.load) begin
        start     = 1'b1;
        state_nxt = CONV;
      end
      CONV: if (cnt == CW'(WIDTH - 1)) begin
        done      = 1'b1;
        state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  // One double-dabble iteration: add 3 to nibbles >= 5, then shift {bcd, bin}.
  always_comb begin
    bcd_adj = bcd;
    for (int i = 0; i < NB; i++) begin
      if (bcd[i*4 +: 4] >= 4'd5) bcd_adj[i*4 +: 4] = bcd[i*4 +: 4] + 4'd3;
    end
    cat_shift = {bcd_adj, bin} << 1;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      bin      <= '0;
      bcd      <= '0;
      cnt      <= '0;
      ovf_next <= 1'b0;
      ovf_q    <= 1'b0;
      shadow   <= '0;
    end else if (start) begin
      bin      <= bus.value;
      bcd      <= '0;
      cnt      <= '0;
      ovf_next <= (64'(bus.value) >= OVF_LIMIT);
    end else if (state == CONV) begin
      bcd <= cat_shift[NB*4+WIDTH-1:WIDTH];
      bin <= cat_shift[WIDTH-1:0];
      cnt <= cnt + CW'(1);
      if (done) begin
        // The final iteration's result goes straight to the shadow on the last edge.
        shadow <= ovf_next ? '1 : cat_shift[WIDTH +: DIGITS*4];
        ovf_q  <= ovf_next;
      end
    end
  end

  assign tick    = (presc == PW'(DIV - 1));
  assign idx_nxt = (idx == IW'(DIGITS - 1)) ? '0 : idx + IW'(1);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      presc <= '0;
      idx   <= '0;
      sel_q <= ~DIGITS'(1);
    end else begin
      presc <= tick ? '0 : presc + PW'(1);
      if (tick) begin
        idx   <= idx_nxt;
        sel_q <= ~(DIGITS'(1) << idx_nxt);
      end
    end
  end

  // Leading-zero blanking on read; digit 0 always shows so a zero value reads "0".
  always_comb begin
    lead = 1'b1;
    nib  = 4'h0;
    for (int i = DIGITS - 1; i >= 0; i--) begin
      nib = shadow[i*4 +: 4];
      if ((LZB != 0) && lead && (i != 0) && (nib == 4'h0)) shown[i] = 4'hF;
      else                                                 shown[i] = nib;
      if (nib != 4'h0) lead = 1'b0;
    end
  end

  assign bus.busy       = (state == CONV);
  assign bus.ovf        = ovf_q;
  assign bus.digit_sel  = sel_q;
  assign bus.digit_code = shown[idx];

endmodule

// File: tb/tb_ssd_scan_ctrl.sv
module tb_ssd_scan_ctrl;
  localparam int DIGITS = 4;
  localparam int WIDTH  = 14;
  localparam int DIV    = 4;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic load = 1'b0;
  logic [WIDTH-1:0] value = '0;
  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  ssd_scan_ctrl_if #(.DIGITS(DIGITS), .WIDTH(WIDTH)) if_lz ();
  ssd_scan_ctrl_if #(.DIGITS(DIGITS), .WIDTH(WIDTH)) if_nz ();

  assign if_lz.load  = load;
  assign if_lz.value = value;
  assign if_nz.load  = load;
  assign if_nz.value = value;

  ssd_scan_ctrl #(.DIGITS(DIGITS), .WIDTH(WIDTH), .DIV(DIV), .LZB(1)) dut_lz (
    .clk(clk), .rst_n(rst_n), .bus(if_lz.slave));
  ssd_scan_ctrl #(.DIGITS(DIGITS), .WIDTH(WIDTH), .DIV(DIV), .LZB(0)) dut_nz (
    .clk(clk), .rst_n(rst_n), .bus(if_nz.slave));

  // Behavioural model: cycles since reset, remaining busy cycles, displayed value.
  int m_cyc = 0;
  int m_busy_left = 0;
  int m_pend = 0;
  int m_val = 0;
  bit m_ovf = 1'b0;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_cyc = 0; m_busy_left = 0; m_pend = 0; m_val = 0; m_ovf = 1'b0;
    end else begin
      m_cyc++;
      if (m_busy_left > 0) begin
        m_busy_left--;
        if (m_busy_left == 0) begin
          m_val = m_pend;
          m_ovf = (m_pend >= 10**DIGITS);
        end
      end else if (load) begin
        m_busy_left = WIDTH;
        m_pend = int'(value);
      end
    end
  end

  function automatic int m_idx();
    return (m_cyc / DIV) % DIGITS;
  endfunction

  function automatic logic [3:0] exp_code(input int val, input bit ovf, input bit lzb, input int i);
    int p;
    p = 1;
    for (int k = 0; k < i; k++) p = p * 10;
    if (ovf) return 4'hF;
    if (lzb && i > 0 && val < p) return 4'hF;
    return 4'((val / p) % 10);
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  always @(negedge clk) begin
    logic [DIGITS-1:0] es;
    es = ~(DIGITS'(1) << m_idx());
    chk("busy_lz", 32'(if_lz.busy), 32'(m_busy_left > 0));
    chk("busy_nz", 32'(if_nz.busy), 32'(m_busy_left > 0));
    chk("ovf_lz", 32'(if_lz.ovf), 32'(m_ovf));
    chk("ovf_nz", 32'(if_nz.ovf), 32'(m_ovf));
    chk("sel_lz", 32'(if_lz.digit_sel), 32'(es));
    chk("sel_nz", 32'(if_nz.digit_sel), 32'(es));
    chk("code_lz", 32'(if_lz.digit_code), 32'(exp_code(m_val, m_ovf, 1'b1, m_idx())));
    chk("code_nz", 32'(if_nz.digit_code), 32'(exp_code(m_val, m_ovf, 1'b0, m_idx())));
  end

  task automatic do_load(input int v);
    @(negedge clk);
    load = 1'b1;
    value = WIDTH'(v);
    @(negedge clk);
    load = 1'b0;
  endtask

  task automatic wait_idle();
    int n;
    n = 0;
    while ((if_lz.busy || if_nz.busy) && n < 100) begin
      @(negedge clk);
      n++;
    end
    if (n >= 100) chk("idle_timeout", 32'(if_lz.busy), 32'd0);
  endtask

  // Literal expectations e0..e3 (digit 0 first), checked for ncyc cycles.
  task automatic expect_frame(input string name, input bit nz, input logic [3:0] e0,
                              input logic [3:0] e1, input logic [3:0] e2,
                              input logic [3:0] e3, input int ncyc);
    logic [3:0] e;
    for (int c = 0; c < ncyc; c++) begin
      case (m_idx())
        0: e = e0;
        1: e = e1;
        2: e = e2;
        default: e = e3;
      endcase
      if (nz) chk(name, 32'(if_nz.digit_code), 32'(e));
      else    chk(name, 32'(if_lz.digit_code), 32'(e));
      @(negedge clk);
    end
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    int n;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    repeat (5) @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    chk("rst_busy", 32'(if_lz.busy), 32'd0);
    chk("rst_ovf", 32'(if_lz.ovf), 32'd0);
    chk("rst_sel", 32'(if_lz.digit_sel), 32'b1110);
    chk("rst_code", 32'(if_lz.digit_code), 32'h0);
    @(negedge clk);
    rst_n = 1'b1;
    for (int i = 0; i < DIV; i++) begin
      #1 chk("rst_hold_sel", 32'(if_lz.digit_sel), 32'b1110);
      @(negedge clk);
    end
    #1 chk("rst_next_sel", 32'(if_lz.digit_sel), 32'b1101);

    do_load(1234);
    n = 0;
    while (if_lz.busy && n < 100) begin
      n++;
      @(negedge clk);
    end
    chk("busy_len", 32'(n), 32'd14);
    expect_frame("f1234", 1'b0, 4'h4, 4'h3, 4'h2, 4'h1, 20);

    do_load(7);    wait_idle();
    expect_frame("f7_lz", 1'b0, 4'h7, 4'hF, 4'hF, 4'hF, 16);
    expect_frame("f7_nz", 1'b1, 4'h7, 4'h0, 4'h0, 4'h0, 16);
    do_load(0);    wait_idle();
    expect_frame("f0", 1'b0, 4'h0, 4'hF, 4'hF, 4'hF, 16);
    do_load(1005); wait_idle();
    expect_frame("f1005", 1'b0, 4'h5, 4'h0, 4'h0, 4'h1, 16);

    do_load(10000); wait_idle();
    chk("ovf_set", 32'(if_lz.ovf), 32'd1);
    expect_frame("fovf", 1'b0, 4'hF, 4'hF, 4'hF, 4'hF, 16);
    do_load(42);   wait_idle();
    chk("ovf_clr", 32'(if_lz.ovf), 32'd0);
    expect_frame("f42", 1'b0, 4'h2, 4'h4, 4'hF, 4'hF, 16);

    do_load(1234);
    @(negedge clk);
    load = 1'b1;
    value = WIDTH'(9999);
    n = 0;
    while (if_lz.busy && n < 100) begin
      n++;
      @(negedge clk);
    end
    @(negedge clk);
    load = 1'b0;
    chk("reload_busy", 32'(if_lz.busy), 32'd1);
    expect_frame("keep1234", 1'b0, 4'h4, 4'h3, 4'h2, 4'h1, 12);
    wait_idle();
    expect_frame("f9999", 1'b0, 4'h9, 4'h9, 4'h9, 4'h9, 16);

    do_load(5678); wait_idle();
    expect_frame("f5678", 1'b0, 4'h8, 4'h7, 4'h6, 4'h5, 16);
    do_load(1111);
    repeat (5) @(negedge clk);
    #2 rst_n = 1'b0;
    #1 chk("abort_busy", 32'(if_lz.busy), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    expect_frame("fabort_lz", 1'b0, 4'h0, 4'hF, 4'hF, 4'hF, 16);
    expect_frame("fabort_nz", 1'b1, 4'h0, 4'h0, 4'h0, 4'h0, 16);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
